count_seq_arbiter: RTL and testbench
====================================

Name: count_seq_arbiter

Overview:
Controller that shares one loadable up/down counter among NREQ requesters. Each requester submits a command (start value, end value, direction, repeat count) over a valid/ready handshake. The block arbitrates round-robin, loads the counter, runs it to the end value for 1+reps passes, then reports completion with the requester ID. It sits between software-style command sources and the counter datapath.

Parameters:
WIDTH, 4, counter and start/end value width
NREQ, 2, number of requesters (2..8)
REP_W, 2, width of the repeat-count field (extra passes)
ID_W, 1, width of the requester ID, equal to clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  per-requester accept strobe, one-hot or zero
req_start  in  NREQ*WIDTH  packed start values, requester i at slice [i*WIDTH +: WIDTH]
req_end  in  NREQ*WIDTH  packed end values
req_dir  in  NREQ  1 = count up, 0 = count down
req_reps  in  NREQ*REP_W  extra passes after the first
count  out  WIDTH  current counter value
busy  out  1  high in every state except IDLE
done_valid  out  1  completion valid
done_id  out  ID_W  requester that completed
done_ready  in  1  completion consumer accept

Behaviour:
- Reset (async): state=IDLE, count=0, req_ready=0, done_valid=0, done_id=0, busy=0, rr pointer=0, latched command=0.
- FSM states are IDLE, LOAD, RUN, DONE.
- IDLE:
  - Round-robin grant among asserted req_valid, starting search at the rr pointer.
  - For the winner, req_ready[i]=1 for exactly this cycle (combinational from state + valid + pointer).
  - Latch start/end/dir/reps and the ID. Next state is LOAD.
  - No valid requests: stay in IDLE, req_ready=0.
- LOAD: drive the counter load with the latched start. count==start from the next cycle. Next state is RUN.
- RUN:
  - Compare the registered count with end. If they are not equal, step the counter (+1 if dir=1, -1 if dir=0) and stay in RUN.
  - If they are equal and reps_left != 0: decrement reps_left, next state is LOAD.
  - If they are equal and reps_left == 0: next state is DONE.
  - The counter does not step on the equal cycle.
- Arithmetic is modulo 2^WIDTH, with wrap-around in both directions. Distance per pass is d = (end-start) mod 2^WIDTH when counting up, or (start-end) mod 2^WIDTH when counting down.
- Latency:
  - Accept cycle is T. Single pass: done_valid first high at T+3+d.
  - Each extra pass adds d+2 cycles.
  - start==end gives d=0, so one RUN cycle per pass.
- DONE:
  - done_valid=1 and done_id are held stable until done_ready=1.
  - The handshake completes when done_valid & done_ready. The rr pointer then moves to (granted ID+1) mod NREQ, and next state is IDLE.
  - count holds its value in DONE and IDLE.
- New commands are never accepted while busy. req_ready stays 0 outside IDLE.
- A requester dropping req_valid after its accept has no effect.
- Reset asserted mid-operation: immediate return to reset values. The in-flight command is discarded and no done is reported.
- If done_ready is already high on the first DONE cycle, the block completes in that cycle, giving one DONE cycle.

Decomposition:
- Package count_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - a typedef for the latched command struct (start, end, dir, reps, id);
  - the localparam for the reset count value.
- One sub-module, updown_load_counter (WIDTH param; clk, rst, load, en, up, data_in, count). It has async reset to 0, load having priority over en, and steps only when en=1.
- Arbiter and FSM stay in the top level.

Test Plan:
- req0: start=3, end=6, up, reps=0, accepted at T.
  - count 3,4,5,6 on T+2..T+5.
  - done_valid at T+6 with done_id=0.
- req1: start=2, end=14, down, reps=0.
  - count wraps 2,1,0,15,14; d=4.
  - done_valid at T+7 with done_id=1.
- Both requests valid in IDLE after reset.
  - req_ready=2'b01 first.
  - After done handshake the rr pointer is 1, so the next grant is req1 even with req0 still valid.
- start=5, end=5, reps=2: three passes of LOAD+1 RUN, count constant at 5, done_valid at T+7.
- done_ready held low 5 cycles in DONE.
  - done_valid and done_id stay stable, busy=1, req_ready stays 0 despite a valid request.
- rst pulsed during RUN (count=4 of 3→9 up).
  - Outputs return to 0 / IDLE asynchronously, with no done_valid pulse.
  - A following command runs correctly.

Source files
------------

// File: rtl/count_seq_pkg.sv
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared types and constants for the count sequencer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_seq_pkg;

    localparam int c_max_w     = 32;
    localparam int c_max_rep_w = 8;
    localparam int c_max_id_w  = 3;

    localparam logic [c_max_w-1:0] c_rst_count = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Fields are sized for the largest supported configuration; instances
    // use only the low bits and leave the rest at zero.
    typedef struct packed {
        logic [c_max_w-1:0]     start_val;
        logic [c_max_w-1:0]     end_val;
        logic                   dir;
        logic [c_max_rep_w-1:0] reps;
        logic [c_max_id_w-1:0]  id;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/updown_load_counter.sv
// ============================================================================
// Module      : updown_load_counter
// Description : Loadable modulo-2^WIDTH up/down counter, load beats enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_load_counter
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_rst_count[WIDTH-1:0];
        end else if (load) begin
            r_count <= data_in;
        end else if (en) begin
            r_count <= up ? (r_count + c_one) : (r_count - c_one);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/count_seq_arbiter.sv
// ============================================================================
// Module      : count_seq_arbiter
// Description : Round-robin shares one loadable up/down counter among NREQ
//               command sources and reports completion with the source ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_arbiter
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int REP_W = 2,
    parameter int ID_W  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_start,
    input  logic [NREQ*WIDTH-1:0] req_end,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*REP_W-1:0] req_reps,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done_valid,
    output logic [ID_W-1:0]       done_id,
    input  logic                  done_ready
);

    localparam logic [c_max_rep_w-1:0] c_rep_one = {{(c_max_rep_w-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]        c_id_one  = {{(ID_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    cmd_t             r_cmd;
    cmd_t             w_new_cmd;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  w_gnt_id;
    logic [ID_W-1:0]  w_id;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ID_W:0]    w_sum;
    logic             w_found;
    logic             w_at_end;
    logic             w_load;
    logic             w_en;
    logic             w_unused_bits;

    logic [WIDTH-1:0] w_start [NREQ];
    logic [WIDTH-1:0] w_end   [NREQ];
    logic [REP_W-1:0] w_reps  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_start[gi] = req_start[gi*WIDTH +: WIDTH];
            assign w_end[gi]   = req_end[gi*WIDTH +: WIDTH];
            assign w_reps[gi]  = req_reps[gi*REP_W +: REP_W];
        end
    endgenerate

    // First asserted requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NREQ)) begin
                w_sum = w_sum - (ID_W+1)'(NREQ);
            end
            if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == ST_IDLE && w_found) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_comb begin
        w_new_cmd                        = '0;
        w_new_cmd.start_val[WIDTH-1:0]   = w_start[w_gnt_id];
        w_new_cmd.end_val[WIDTH-1:0]     = w_end[w_gnt_id];
        w_new_cmd.dir                    = req_dir[w_gnt_id];
        w_new_cmd.reps[REP_W-1:0]        = w_reps[w_gnt_id];
        w_new_cmd.id[ID_W-1:0]           = w_gnt_id;
    end

    assign w_id      = r_cmd.id[ID_W-1:0];
    assign w_at_end  = (count == r_cmd.end_val[WIDTH-1:0]);
    assign w_ptr_nxt = (w_id == ID_W'(NREQ-1)) ? '0 : (w_id + c_id_one);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_at_end)              w_en        = 1'b1;
                else if (r_cmd.reps != '0)  w_state_nxt = ST_LOAD;
                else                        w_state_nxt = ST_DONE;
            end
            ST_DONE: if (done_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_found) begin
                r_cmd <= w_new_cmd;
            end else if (r_state == ST_RUN && w_at_end && r_cmd.reps != '0) begin
                r_cmd.reps <= r_cmd.reps - c_rep_one;
            end
            if (r_state == ST_DONE && done_ready) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    updown_load_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .en      (w_en),
        .up      (r_cmd.dir),
        .data_in (r_cmd.start_val[WIDTH-1:0]),
        .count   (count)
    );

    assign busy       = (r_state != ST_IDLE);
    assign done_valid = (r_state == ST_DONE);
    assign done_id    = w_id;

    // Upper struct bits beyond the configured widths are constant zero.
    assign w_unused_bits = ^r_cmd;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_arbiter.sv
// ============================================================================
// Module      : tb_count_seq_arbiter
// Description : Directed self-checking bench for count_seq_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;
    localparam int REP_W = 2;
    localparam int ID_W  = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_start = '0;
    logic [NREQ*WIDTH-1:0] req_end = '0;
    logic [NREQ-1:0]       req_dir = '0;
    logic [NREQ*REP_W-1:0] req_reps = '0;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic                  done_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    count_seq_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .REP_W (REP_W),
        .ID_W  (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_start  (req_start),
        .req_end    (req_end),
        .req_dir    (req_dir),
        .req_reps   (req_reps),
        .count      (count),
        .busy       (busy),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_ready (done_ready)
    );

    always #5 clk = ~clk;

    task automatic set_cmd(input int id, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                           input logic d, input logic [REP_W-1:0] r);
        req_start[id*WIDTH +: WIDTH] = s;
        req_end[id*WIDTH +: WIDTH]   = e;
        req_dir[id]                  = d;
        req_reps[id*REP_W +: REP_W]  = r;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; done_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
        checks++; if (done_id !== 1'b0) begin failures++; $display("FAIL reset_done_id got=%b exp=0", done_id); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // req0 3->6 up, then req1 2->14 down with wrap; both valid throughout req0.
    task automatic test_rr_up_down;
        logic [WIDTH-1:0] exp_dn [5] = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
        set_cmd(0, 4'd3, 4'd6, 1'b1, 2'd0);
        set_cmd(1, 4'd2, 4'd14, 1'b0, 2'd0);
        req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_first_grant got=%b exp=01", req_ready); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checks++; if (count !== 4'(c + 1)) begin failures++; $display("FAIL up_count c=%0d got=%0d exp=%0d", c, count, c + 1); end
            end
            checks++; if (done_valid !== (c == 6)) begin failures++; $display("FAIL up_done_valid c=%0d got=%b exp=%b", c, done_valid, (c == 6)); end
            checks++; if (req_ready !== ((c == 7) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL rr_ready c=%0d got=%b", c, req_ready); end
            if (c == 6) begin
                checks++; if (done_id !== 1'b0) begin failures++; $display("FAIL up_done_id got=%b exp=0", done_id); end
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                checks++; if (count !== exp_dn[c-2]) begin failures++; $display("FAIL down_count c=%0d got=%0d exp=%0d", c, count, exp_dn[c-2]); end
            end
            if (c <= 7) begin
                checks++; if (done_valid !== (c == 7)) begin failures++; $display("FAIL down_done_valid c=%0d got=%b", c, done_valid); end
            end
            if (c == 7) begin
                checks++; if (done_id !== 1'b1) begin failures++; $display("FAIL down_done_id got=%b exp=1", done_id); end
            end
            if (c == 8) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL down_idle_busy got=%b exp=0", busy); end
            end
        end
    endtask

    // start==end with two extra passes: three LOAD+RUN pairs.
    task automatic test_reps_equal;
        set_cmd(0, 4'd5, 4'd5, 1'b1, 2'd2);
        @(posedge clk); #1 req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL reps_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 7) begin
                checks++; if (count !== 4'd5) begin failures++; $display("FAIL reps_count c=%0d got=%0d exp=5", c, count); end
            end
            if (c <= 7) begin
                checks++; if (done_valid !== (c == 7)) begin failures++; $display("FAIL reps_done_valid c=%0d got=%b", c, done_valid); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reps_busy c=%0d got=%b exp=1", c, busy); end
            end else begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reps_idle got=%b exp=0", busy); end
            end
        end
    endtask

    // done_ready held low: outputs hold and no new grant despite req0 valid.
    task automatic test_done_stall;
        bit seen;
        set_cmd(1, 4'd0, 4'd1, 1'b1, 2'd0);
        set_cmd(0, 4'd7, 4'd7, 1'b1, 2'd0);
        @(posedge clk); #1 done_ready = 1'b0; req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL stall_grant got=%b exp=10", req_ready); end
        @(posedge clk); #1 req_valid = 2'b01;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (done_valid !== 1'b1) begin failures++; $display("FAIL stall_done_valid k=%0d got=%b exp=1", k, done_valid); end
            checks++; if (done_id !== 1'b1) begin failures++; $display("FAIL stall_done_id k=%0d got=%b exp=1", k, done_id); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy k=%0d got=%b exp=1", k, busy); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_req_ready k=%0d got=%b exp=00", k, req_ready); end
            checks++; if (count !== 4'd1) begin failures++; $display("FAIL stall_count k=%0d got=%0d exp=1", k, count); end
        end
        @(posedge clk); #1 done_ready = 1'b1;
        @(negedge clk);
        checks++; if (done_valid !== 1'b1) begin failures++; $display("FAIL stall_release_valid got=%b exp=1", done_valid); end
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL stall_next_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (done_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL stall_followup_timeout got=0 exp=1"); end
        checks++; if (done_id !== 1'b0) begin failures++; $display("FAIL stall_followup_id got=%b exp=0", done_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_followup_idle got=%b exp=0", busy); end
    endtask

    // Asynchronous reset during RUN, then a clean follow-up command.
    task automatic test_mid_reset;
        set_cmd(0, 4'd3, 4'd9, 1'b1, 2'd0);
        @(posedge clk); #1 req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mrst_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL mrst_pre_count got=%0d exp=4", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL mrst_count got=%0d exp=0", count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL mrst_done_valid got=%b exp=0", done_valid); end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (done_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mrst_quiet k=%0d got=%b%b exp=00", k, done_valid, busy); end
        end
        set_cmd(1, 4'd1, 4'd3, 1'b1, 2'd0);
        @(posedge clk); #1 req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL mrst_next_grant got=%b exp=10", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++; if (count !== 4'(c - 1)) begin failures++; $display("FAIL mrst_next_count c=%0d got=%0d exp=%0d", c, count, c - 1); end
            end
            checks++; if (done_valid !== (c == 5)) begin failures++; $display("FAIL mrst_next_done c=%0d got=%b", c, done_valid); end
            if (c == 5) begin
                checks++; if (done_id !== 1'b1) begin failures++; $display("FAIL mrst_next_id got=%b exp=1", done_id); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_up_down();
        test_reps_equal();
        test_done_stall();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
